// File: rtl/porta_ctrl_pkg.sv
// porta_ctrl_pkg: shared types and constants for the controller port scanner
package porta_ctrl_pkg;
    typedef enum logic [1:0] {JOY_SETTLE, JOY_SAMPLE, KPD_SETTLE, KPD_SAMPLE} scan_state_t;
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int P3 = 2;
    localparam int P4 = 3;
    localparam int P6 = 4;
    localparam int P7 = 5;
    localparam int P9 = 6;
    localparam logic [6:0] CTRL_RELEASED = 7'h7F;
endpackage

// File: rtl/porta_ctrl_debounce.sv
// porta_ctrl_debounce: commits a 7-pin sample once it repeats on DEBOUNCE_SCANS consecutive scans
module porta_ctrl_debounce import porta_ctrl_pkg::*; #(
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] sample,
    output logic [6:0] value
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_SCANS);
    logic [6:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    always_comb cnt_nxt = (sample != cand) ? CW'(1) : (cnt == FULL) ? FULL : cnt + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            cand  <= CTRL_RELEASED;
            cnt   <= '0;
            value <= CTRL_RELEASED;
        end else if (en) begin
            cand <= sample;
            cnt  <= cnt_nxt;
            if (cnt_nxt == FULL) value <= sample;
        end
    end
endmodule

// File: rtl/porta_ctrl_scanner.sv
// porta_ctrl_scanner: alternates joystick/keypad selects, debounces both controller ports
// into four registers and serves CPU reads from them independent of scan phase.
module porta_ctrl_scanner import porta_ctrl_pkg::*; #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] c1_in,
    input  logic [6:0] c2_in,
    output logic       sel_joy_n,
    output logic       sel_kpd_n,
    input  logic       mode_kpd_wr,
    input  logic       mode_joy_wr,
    input  logic       rd_en,
    input  logic       rd_player,
    output logic [7:0] rd_data,
    output logic       scan_done
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(SETTLE_CYCLES - 1);
    scan_state_t   st;
    scan_state_t   st_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [6:0]    c1_m, c1_s, c2_m, c2_s;
    logic [6:0]    joy1, kpd1, joy2, kpd2;
    logic          dead, mode_kpd, settle;
    always_comb begin
        st_nxt = st;
        settle = (st == JOY_SETTLE) || (st == KPD_SETTLE);
        case (st)
            JOY_SETTLE: st_nxt = (cnt == '0) ? JOY_SAMPLE : JOY_SETTLE;
            JOY_SAMPLE: st_nxt = KPD_SETTLE;
            KPD_SETTLE: st_nxt = (cnt == '0) ? KPD_SAMPLE : KPD_SETTLE;
            default:    st_nxt = JOY_SETTLE;
        endcase
        cnt_nxt = settle ? cnt - 1'b1 : LOAD;
    end
    // dead marks the first settle cycle after a switch, when both selects stay high
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= JOY_SETTLE;
            cnt       <= LOAD;
            dead      <= 1'b0;
            scan_done <= 1'b0;
            mode_kpd  <= 1'b0;
            rd_data   <= 8'hFF;
            c1_m      <= CTRL_RELEASED;
            c1_s      <= CTRL_RELEASED;
            c2_m      <= CTRL_RELEASED;
            c2_s      <= CTRL_RELEASED;
        end else begin
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            dead      <= (st == JOY_SAMPLE) || (st == KPD_SAMPLE);
            scan_done <= st == KPD_SAMPLE;
            mode_kpd  <= mode_joy_wr ? 1'b0 : mode_kpd_wr ? 1'b1 : mode_kpd;
            c1_m      <= c1_in;
            c1_s      <= c1_m;
            c2_m      <= c2_in;
            c2_s      <= c2_m;
            if (rd_en) rd_data <= {1'b1, mode_kpd ? (rd_player ? kpd2 : kpd1) : (rd_player ? joy2 : joy1)};
        end
    end
    assign sel_joy_n = rst | dead | !((st == JOY_SETTLE) || (st == JOY_SAMPLE));
    assign sel_kpd_n = rst | dead | !((st == KPD_SETTLE) || (st == KPD_SAMPLE));
    porta_ctrl_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_joy1 (
        .clk(clk), .rst(rst), .en(st == JOY_SAMPLE), .sample(c1_s), .value(joy1));
    porta_ctrl_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_kpd1 (
        .clk(clk), .rst(rst), .en(st == KPD_SAMPLE), .sample(c1_s), .value(kpd1));
    porta_ctrl_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_joy2 (
        .clk(clk), .rst(rst), .en(st == JOY_SAMPLE), .sample(c2_s), .value(joy2));
    porta_ctrl_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_kpd2 (
        .clk(clk), .rst(rst), .en(st == KPD_SAMPLE), .sample(c2_s), .value(kpd2));
endmodule

// File: tb/tb_porta_ctrl_scanner.sv
// tb_porta_ctrl_scanner: directed and random checks of the scanner against a phase/history model
module tb_porta_ctrl_scanner;
    localparam int SC  = 16;
    localparam int DEB = 2;
    localparam int PER = 2 * (SC + 1);
    logic       clk = 0;
    logic       rst = 1;
    logic [6:0] c1_in = 7'h7F;
    logic [6:0] c2_in = 7'h7F;
    logic       sel_joy_n, sel_kpd_n, scan_done;
    logic       mode_kpd_wr = 0;
    logic       mode_joy_wr = 0;
    logic       rd_en = 0;
    logic       rd_player = 0;
    logic [7:0] rd_data;
    int checks = 0;
    int fails = 0;
    int k;
    int sd_at;
    bit bounce = 0;
    bit hit;
    logic [6:0] pat_c1j = 7'h7F, pat_c1k = 7'h7F, pat_c2j = 7'h7F, pat_c2k = 7'h7F;
    logic [6:0] cm [4];
    logic [6:0] hist [4][DEB];
    int         nseen [4];
    logic       mmode;
    logic [7:0] mrd;
    logic [6:0] d1a, d2a, d1b, d2b;

    porta_ctrl_scanner #(.SETTLE_CYCLES(SC), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .rst(rst), .c1_in(c1_in), .c2_in(c2_in),
        .sel_joy_n(sel_joy_n), .sel_kpd_n(sel_kpd_n),
        .mode_kpd_wr(mode_kpd_wr), .mode_joy_wr(mode_joy_wr),
        .rd_en(rd_en), .rd_player(rd_player), .rd_data(rd_data), .scan_done(scan_done));

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            cm[c] = 7'h7F;
            nseen[c] = 0;
            for (int j = 0; j < DEB; j++) hist[c][j] = 7'h7F;
        end
        mmode = 0;
        mrd = 8'hFF;
        d1a = 7'h7F;
        d2a = 7'h7F;
        d1b = 7'h7F;
        d2b = 7'h7F;
        k = 0;
    endfunction

    // a value becomes committed once the last DEB samples of its channel all agree
    function automatic void push(input int ch, input logic [6:0] v);
        bit same;
        same = 1;
        for (int j = DEB - 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
        hist[ch][0] = v;
        nseen[ch]++;
        for (int j = 0; j < DEB; j++) if (hist[ch][j] != v) same = 0;
        if (nseen[ch] >= DEB && same) cm[ch] = v;
    endfunction

    function automatic bit will_commit(input int ch, input logic [6:0] v);
        if (v == cm[ch] || nseen[ch] < DEB - 1) return 0;
        for (int j = 0; j < DEB - 1; j++) if (hist[ch][j] != v) return 0;
        return 1;
    endfunction

    task automatic cyc();
        int p;
        bit jw, kw;
        logic [6:0] cj;
        p = k % PER;
        jw = p >= 1 && p <= SC;
        kw = p >= SC + 2;
        cj = bounce ? (((k / PER) % 2) != 0 ? 7'h7E : 7'h7F) : pat_c1j;
        c1_in = jw ? cj : kw ? pat_c1k : 7'h7F;
        c2_in = jw ? pat_c2j : kw ? pat_c2k : 7'h7F;
        @(negedge clk);
        if (rst) begin
            chk("sel_joy_rst", {7'b0, sel_joy_n}, 8'h01);
            chk("sel_kpd_rst", {7'b0, sel_kpd_n}, 8'h01);
        end else begin
            chk("sel_joy_n", {7'b0, sel_joy_n}, {7'b0, !(p <= SC && !(p == 0 && k > 0))});
            chk("sel_kpd_n", {7'b0, sel_kpd_n}, {7'b0, !(p > SC + 1)});
            chk("scan_done", {7'b0, scan_done}, {7'b0, p == 0 && k > 0});
            chk("rd_data", rd_data, mrd);
            if (scan_done && sd_at < 0) sd_at = k;
        end
        if (rst) model_reset();
        else begin
            if (rd_en) mrd = {1'b1, cm[{rd_player, mmode}]};
            if (mode_joy_wr) mmode = 0;
            else if (mode_kpd_wr) mmode = 1;
            if (p == SC) begin
                push(0, d2a);
                push(2, d2b);
            end
            if (p == PER - 1) begin
                push(1, d2a);
                push(3, d2b);
            end
            d2a = d1a;
            d1a = c1_in;
            d2b = d1b;
            d1b = c2_in;
            k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic pl, input string tag, input logic [7:0] exp);
        rd_player = pl;
        rd_en = 1;
        cyc();
        rd_en = 0;
        cyc();
        chk(tag, rd_data, exp);
    endtask

    task automatic pulse(input bit kpd, input bit joy);
        mode_kpd_wr = kpd;
        mode_joy_wr = joy;
        cyc();
        mode_kpd_wr = 0;
        mode_joy_wr = 0;
    endtask

    initial begin
        model_reset();
        sd_at = -1;
        @(posedge clk);
        #1;
        repeat (3) cyc();
        rst = 0;
        chk("rd_after_reset", rd_data, 8'hFF);
        for (int i = 0; i < 100 && sd_at < 0; i++) cyc();
        chk("first_scan_done", 8'(sd_at), 8'(PER));
        bounce = 1;
        for (int s = 0; s < 6; s++) begin
            repeat (PER - 2) cyc();
            rd(0, "bounce_joy1", 8'hFF);
        end
        bounce = 0;
        pat_c1j = 7'h7E;
        repeat (3 * PER) cyc();
        rd(0, "joy1_commit", 8'hFE);
        pulse(1, 0);
        rd(0, "kpd1_untouched", 8'hFF);
        pat_c2k = 7'h3B;
        repeat (3 * PER) cyc();
        rd(1, "kpd2_commit", 8'hBB);
        pulse(0, 1);
        rd(1, "joy2_untouched", 8'hFF);
        pulse(1, 0);
        pulse(1, 1);
        rd(0, "simul_mode_joy", 8'hFE);
        mode_kpd_wr = 1;
        rd(0, "rd_with_mode_wr", 8'hFE);
        rd(0, "mode_after_wr", 8'hFF);
        pulse(0, 1);
        pat_c1j = 7'h7D;
        hit = 0;
        for (int i = 0; i < 4 * PER && !hit; i++) begin
            if (k % PER == SC && will_commit(0, d2a)) begin
                hit = 1;
                rd(0, "rd_in_commit_cycle", 8'hFE);
            end else cyc();
        end
        chk("commit_cycle_found", {7'b0, hit}, 8'h01);
        rd(0, "rd_after_commit", 8'hFD);
        for (int i = 0; i < 12 * PER; i++) begin
            if (k % PER == 0) begin
                pat_c1j = ($urandom % 2 != 0) ? pat_c1j : 7'($urandom);
                pat_c1k = ($urandom % 2 != 0) ? pat_c1k : 7'($urandom);
                pat_c2j = ($urandom % 2 != 0) ? pat_c2j : 7'($urandom);
                pat_c2k = ($urandom % 2 != 0) ? pat_c2k : 7'($urandom);
            end
            rd_en = ($urandom % 4) == 0;
            rd_player = 1'($urandom % 2);
            mode_kpd_wr = ($urandom % 16) == 0;
            mode_joy_wr = ($urandom % 16) == 0;
            cyc();
        end
        rd_en = 0;
        mode_kpd_wr = 0;
        mode_joy_wr = 0;
        pat_c1j = 7'h7E;
        pat_c2k = 7'h3B;
        repeat (3 * PER) cyc();
        for (int i = 0; i < 2 * PER && (k % PER) != SC + 5; i++) cyc();
        chk("reached_kpd_settle", 8'(k % PER), 8'(SC + 5));
        pat_c1j = 7'h7F;
        pat_c1k = 7'h7F;
        pat_c2j = 7'h7F;
        pat_c2k = 7'h7F;
        rst = 1;
        repeat (2) cyc();
        rst = 0;
        chk("rd_after_mid_reset", rd_data, 8'hFF);
        cyc();
        rd(0, "mid_rst_joy1", 8'hFF);
        rd(1, "mid_rst_joy2", 8'hFF);
        pulse(1, 0);
        rd(0, "mid_rst_kpd1", 8'hFF);
        rd(1, "mid_rst_kpd2", 8'hFF);
        repeat (PER) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/porta_ctrl_scanner.md
# porta_ctrl_scanner

Autonomous scanner for the two ColecoVision controller ports in the portable console glue. It alternates the shared joystick and keypad select lines, samples both controllers' seven input pins after a settle delay, and debounces each (controller, mode) pair into its own register. It serves CPU controller reads from those registers with fixed latency, independent of scan phase. CPU mode writes to I/O ports 0x80 and 0xC0 change only which register set is read; they never drive the select lines.

## Interface
Parameters:
- SETTLE_CYCLES, 16 — clocks the select lines are held before sampling; legal range ≥1.
- DEBOUNCE_SCANS, 2 — consecutive identical samples needed to commit a value; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- c1_in  in  7  controller 1 pins {P9,P7,P6,P4,P3,P2,P1}, active-low, asynchronous.
- c2_in  in  7  controller 2 pins, same ordering.
- sel_joy_n  out  1  joystick common select, active-low.
- sel_kpd_n  out  1  keypad common select, active-low.
- mode_kpd_wr  in  1  one-cycle pulse for a CPU write to port 0x80; selects keypad read mode.
- mode_joy_wr  in  1  one-cycle pulse for a CPU write to port 0xC0; selects joystick read mode.
- rd_en  in  1  CPU controller read strobe.
- rd_player  in  1  0 selects controller 1, 1 selects controller 2 (A1).
- rd_data  out  8  {1'b1, selected register[6:0]}.
- scan_done  out  1  one-cycle pulse at the end of each full joystick+keypad scan.

## Operation
- Inputs pass through a 2-flop synchronizer before any use.
- FSM states and sequence: JOY_SETTLE → JOY_SAMPLE → KPD_SETTLE → KPD_SAMPLE → JOY_SETTLE.
  - Each SETTLE state lasts SETTLE_CYCLES clocks, using a down-counter loaded with SETTLE_CYCLES-1 on entry.
  - Each SAMPLE state lasts exactly 1 clock.
- Select lines:
  - sel_joy_n=0 in JOY_SETTLE and JOY_SAMPLE, otherwise 1.
  - sel_kpd_n=0 in the KPD states, otherwise 1.
  - The two lines are never low together. One dead cycle with both high is inserted on each switch; it is counted as the first settle cycle.
- Debounce channels: there are four, joy1, kpd1, joy2 and kpd2. For each channel in a SAMPLE state:
  - If the synchronized sample equals the channel's candidate, the match counter increments, saturating at DEBOUNCE_SCANS.
  - Otherwise the candidate is set to the sample and the counter to 1.
  - When the counter reaches DEBOUNCE_SCANS, the committed register takes the candidate.
- Read mode register: set to keypad by mode_kpd_wr and to joystick by mode_joy_wr. If both pulses occur in the same cycle, joystick wins.
- Reads:
  - On rd_en, rd_data is loaded with {1'b1, reg}, where reg is chosen by the current mode and rd_player.
  - A commit in the same cycle is not visible; the read returns the pre-commit value.
  - A mode write in the same cycle as rd_en is not visible either; the read uses the old mode.
  - rd_data holds its value between reads.

## Timing
- Reset values:
  - FSM in JOY_SETTLE with the counter loaded; sel_joy_n=1 and sel_kpd_n=1 during reset, and sel_joy_n=0 from the first cycle after reset.
  - Committed registers and candidates 7'h7F; match counters 0; mode joystick.
  - rd_data 8'hFF; scan_done 0.
- Scan period: 2·(SETTLE_CYCLES+1) clocks. With defaults this is 34.
- scan_done is asserted in the cycle after KPD_SAMPLE, i.e. the first JOY_SETTLE cycle.
- Read latency: 1 clock from rd_en to rd_data.
- Input-to-commit latency: at most 2 sync cycles + DEBOUNCE_SCANS·period + 1 clock.
- rst asserted mid-scan: the FSM aborts in the next cycle and all state returns to reset values; no partial commit.
- Counter width: clog2(SETTLE_CYCLES) bits, minimum 1. With SETTLE_CYCLES=1 each SETTLE state lasts exactly 1 cycle.

## Structure
- Package porta_ctrl_pkg contains:
  - the FSM state enum;
  - pin index constants (P1=0 … P9=6);
  - CTRL_RELEASED = 7'h7F.
- Sub-module porta_ctrl_debounce covers one channel (candidate, counter, committed register, sample-enable input). It is instantiated 4×.
- The top level holds the synchronizers, FSM, select drivers, mode register and read mux.

## Test plan
- Reset: hold rst for 3 clocks. Required after release: rd_data=8'hFF, both selects 1 during reset, sel_joy_n=0 on the next cycle, scan_done first asserted 34 clocks later.
- Joystick commit:
  - Stimulus: c1_in=7'h7E (P1 low) applied while sel_joy_n=0, default parameters.
  - Required: after 2 scans, rd_en with rd_player=0 and joystick mode returns 8'hFE; a keypad-mode read of controller 1 still returns 8'hFF.
- Keypad mode:
  - Stimulus: pulse mode_kpd_wr; drive c2_in=7'h3B only while sel_kpd_n=0, else 7'h7F.
  - Required: a read with rd_player=1 returns 8'hBB, and a joystick-mode read returns 8'hFF.
- Bounce rejection: toggle c1_in bit 0 on every scan. Required: the joy1 register never leaves 7'h7F.
- Simultaneous events:
  - Stimulus 1: mode_kpd_wr and mode_joy_wr pulsed in the same cycle. Required: the mode is joystick.
  - Stimulus 2: rd_en asserted in the commit cycle. Required: the old value is returned, and the next read returns the new value.
- Mid-scan reset: assert rst during KPD_SETTLE after a commit. Required: all registers read 8'hFF and the selects restart with joystick.
